// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter shared by instruction fetch and the MEM stage.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate ownership when both ports request together.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_len,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [2:0] LAT = 3'(RAM_LAT);

  state_t            r_state, w_state_next;
  logic [2:0]        r_cnt, w_cnt_next;
  logic [2:0]        r_len, w_len_next;
  logic [ADDR_W-1:0] r_base, w_base_next;
  logic [31:0]       r_wdata, w_wdata_next;
  logic              r_owner_d, w_owner_d_next;
  logic [31:0]       r_asm, w_asm_next;
  logic [31:0]       r_if_data, w_if_data_next;
  logic [31:0]       r_d_rdata, w_d_rdata_next;
  logic              r_if_done, w_if_done_next;
  logic              r_d_done, w_d_done_next;

  logic              w_grant_d, w_grant_if;
  logic [2:0]        w_d_nbytes;
  logic [1:0]        w_cap_idx;
  logic [ADDR_W-1:0] w_cur_addr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = data port owned the most recent transaction
  logic r_last_d;

  always_ff @(posedge clk) begin
    if (rst)
      r_last_d <= 1'b0;
    else if (r_state == IDLE && (d_req || if_req))
      r_last_d <= w_grant_d;
  end

  assign w_grant_d = d_req && (!if_req || !r_last_d);
`else
  assign w_grant_d = d_req;
`endif
  assign w_grant_if = if_req && !w_grant_d;

  assign w_d_nbytes = (d_len == 2'd0) ? 3'd1 : (d_len == 2'd1) ? 3'd2 : 3'd4;
  assign w_cap_idx  = 2'(r_cnt - LAT);
  assign w_cur_addr = r_base + ADDR_W'(r_cnt);

  assign busy    = (r_state != IDLE);
  assign if_done = r_if_done;
  assign d_done  = r_d_done;
  assign if_data = r_if_data;
  assign d_rdata = r_d_rdata;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_len_next     = r_len;
    w_base_next    = r_base;
    w_wdata_next   = r_wdata;
    w_owner_d_next = r_owner_d;
    w_asm_next     = r_asm;
    w_if_data_next = r_if_data;
    w_d_rdata_next = r_d_rdata;
    w_if_done_next = 1'b0;
    w_d_done_next  = 1'b0;
    ram_addr       = '0;
    ram_wr         = 1'b0;
    ram_dout       = 8'h00;
    case (r_state)
      IDLE: begin
        if (w_grant_d || w_grant_if) begin
          w_cnt_next     = 3'd0;
          w_asm_next     = 32'h0;
          w_owner_d_next = w_grant_d;
          if (w_grant_d) begin
            w_base_next  = d_addr;
            w_len_next   = w_d_nbytes;
            w_wdata_next = d_wdata;
            w_state_next = d_we ? WRITE : READ;
          end else begin
            w_base_next  = if_addr;
            w_len_next   = 3'd4;
            w_state_next = READ;
          end
        end
      end
      READ: begin
        w_cnt_next = r_cnt + 3'd1;
        if (r_cnt < r_len)
          ram_addr = w_cur_addr;
        // RAM data lags the address by LAT cycles
        if (r_cnt >= LAT)
          w_asm_next[{w_cap_idx, 3'b000} +: 8] = ram_din;
        if (r_cnt == r_len) begin
          w_state_next = IDLE;
          if (r_owner_d) begin
            w_d_rdata_next = w_asm_next;
            w_d_done_next  = 1'b1;
          end else begin
            w_if_data_next = w_asm_next;
            w_if_done_next = 1'b1;
          end
        end
      end
      WRITE: begin
        w_cnt_next = r_cnt + 3'd1;
        ram_addr   = w_cur_addr;
        ram_wr     = 1'b1;
        ram_dout   = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
        if (r_cnt == r_len - 3'd1) begin
          w_state_next  = IDLE;
          w_d_done_next = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 3'd0;
      r_len     <= 3'd0;
      r_base    <= '0;
      r_wdata   <= 32'h0;
      r_owner_d <= 1'b0;
      r_asm     <= 32'h0;
      r_if_data <= 32'h0;
      r_d_rdata <= 32'h0;
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_len     <= w_len_next;
      r_base    <= w_base_next;
      r_wdata   <= w_wdata_next;
      r_owner_d <= w_owner_d_next;
      r_asm     <= w_asm_next;
      r_if_data <= w_if_data_next;
      r_d_rdata <= w_d_rdata_next;
      r_if_done <= w_if_done_next;
      r_d_done  <= w_d_done_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1 KiB synchronous-read byte RAM model.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        if_req, if_done, d_req, d_we, d_done, ram_wr, busy;
  logic [31:0] if_addr, if_data, d_addr, d_wdata, d_rdata, ram_addr;
  logic [1:0]  d_len;
  logic [7:0]  ram_dout, ram_din;

  logic [7:0]  mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [7:0]  pl_data;

  logic [31:0] s_addr [1:8];
  logic        s_wr   [1:8];
  logic [7:0]  s_dout [1:8];

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(32), .RAM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_len(d_len), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address bits above 9 are ignored, so 0xFFFFFFFF aliases to 0x3FF
  always @(posedge clk) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (ram_wr)
      mem[ram_addr[9:0]] <= ram_dout;
    ram_din <= mem[ram_addr[9:0]];
  end

  task automatic preload(input logic [9:0] a, input logic [7:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic is_if, input logic we,
                         input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [31:0] data);
    lat = 0;
    data = 32'h0;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_len = len; d_addr = addr; d_wdata = wdata;
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i <= 8) begin
        s_addr[i] = ram_addr; s_wr[i] = ram_wr; s_dout[i] = ram_dout;
      end
      if (is_if ? if_done : d_done) begin
        lat = i;
        data = is_if ? if_data : d_rdata;
        if_req = 1'b0;
        d_req = 1'b0;
        break;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    $display("txn %s: addr=%h latency=%0d data=%h", name, addr, lat, data);
    n_checks++;
    if (lat == 0) begin
      n_errors++;
      $display("FAIL %s_timeout: no done pulse within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    preload(10'h100, 8'h13); preload(10'h101, 8'h05);
    preload(10'h102, 8'h50); preload(10'h103, 8'h00);
    preload(10'h203, 8'hF0);
    preload(10'h3FF, 8'hA5); preload(10'h000, 8'h5A);
    preload(10'h080, 8'h11); preload(10'h081, 8'h22);
    preload(10'h082, 8'h33); preload(10'h083, 8'h44);
    n_checks += 7;
    if (busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (if_done !== 1'b0)   begin n_errors++; $display("FAIL reset_if_done: got %b want 0", if_done); end
    if (d_done !== 1'b0)    begin n_errors++; $display("FAIL reset_d_done: got %b want 0", d_done); end
    if (ram_wr !== 1'b0)    begin n_errors++; $display("FAIL reset_ram_wr: got %b want 0", ram_wr); end
    if (ram_addr !== 32'h0) begin n_errors++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
    if (if_data !== 32'h0)  begin n_errors++; $display("FAIL reset_if_data: got %h want 0", if_data); end
    if (d_rdata !== 32'h0)  begin n_errors++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    rst = 1'b0;
    $display("txn reset: outputs sampled while rst high");
  endtask

  task automatic test_word_fetch();
    int lat;
    logic [31:0] data;
    run_txn("word_fetch", 1'b1, 1'b0, 2'd2, 32'h100, 32'h0, lat, data);
    n_checks += 2;
    if (lat !== 6)            begin n_errors++; $display("FAIL fetch_latency: got %0d want 6", lat); end
    if (data !== 32'h00500513) begin n_errors++; $display("FAIL fetch_data: got %h want 00500513", data); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (s_addr[k+1] !== 32'h100 + 32'(k) || s_wr[k+1] !== 1'b0) begin
        n_errors++;
        $display("FAIL fetch_addr%0d: got %h wr=%b want %h wr=0", k, s_addr[k+1], s_wr[k+1], 32'h100 + 32'(k));
      end
    end
  endtask

  task automatic test_byte_load();
    int lat;
    logic [31:0] data;
    run_txn("byte_load", 1'b0, 1'b0, 2'd0, 32'h203, 32'h0, lat, data);
    n_checks += 2;
    if (lat !== 3)            begin n_errors++; $display("FAIL byte_latency: got %0d want 3", lat); end
    if (data !== 32'h000000F0) begin n_errors++; $display("FAIL byte_data: got %h want 000000f0", data); end
  endtask

  task automatic test_word_store();
    int lat;
    logic [31:0] data;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    run_txn("word_store", 1'b0, 1'b1, 2'd2, 32'h40, 32'hDEADBEEF, lat, data);
    n_checks++;
    if (lat !== 5) begin n_errors++; $display("FAIL store_latency: got %0d want 5", lat); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (s_wr[k+1] !== 1'b1 || s_addr[k+1] !== 32'h40 + 32'(k) || s_dout[k+1] !== exp_b[k]) begin
        n_errors++;
        $display("FAIL store_byte%0d: got wr=%b addr=%h dout=%h want wr=1 addr=%h dout=%h",
                 k, s_wr[k+1], s_addr[k+1], s_dout[k+1], 32'h40 + 32'(k), exp_b[k]);
      end
    end
    run_txn("fetch_back", 1'b1, 1'b0, 2'd2, 32'h40, 32'h0, lat, data);
    n_checks++;
    if (data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL store_readback: got %h want deadbeef", data); end
  endtask

  task automatic test_simultaneous();
    int t_d = 0, t_if = 0;
    logic both = 1'b0;
    logic [31:0] dd = 32'h0, id = 32'h0;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_len = 2'd2; d_addr = 32'h80;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (if_done && d_done) both = 1'b1;
      if (d_done && t_d == 0) begin t_d = i; dd = d_rdata; d_req = 1'b0; end
      if (if_done) begin t_if = i; id = if_data; if_req = 1'b0; break; end
    end
    if_req = 1'b0; d_req = 1'b0;
    $display("txn simultaneous: d_done@%0d data=%h if_done@%0d data=%h", t_d, dd, t_if, id);
    n_checks += 5;
    if (t_d !== 6)             begin n_errors++; $display("FAIL simul_d_time: got %0d want 6", t_d); end
    if (t_if !== 12)           begin n_errors++; $display("FAIL simul_if_time: got %0d want 12", t_if); end
    if (dd !== 32'h44332211)   begin n_errors++; $display("FAIL simul_d_data: got %h want 44332211", dd); end
    if (id !== 32'h00500513)   begin n_errors++; $display("FAIL simul_if_data: got %h want 00500513", id); end
    if (both !== 1'b0)         begin n_errors++; $display("FAIL simul_overlap: got both dones high want never"); end
  endtask

  task automatic test_reset_mid_read();
    int lat;
    logic [31:0] data;
    logic seen = 1'b0;
    if_req = 1'b1; if_addr = 32'h80;
    for (int i = 1; i <= 3; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b0;
    rst = 1'b0;
    n_checks += 3;
    if (busy !== 1'b0)     begin n_errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (ram_wr !== 1'b0)   begin n_errors++; $display("FAIL midrst_ram_wr: got %b want 0", ram_wr); end
    if (if_data !== 32'h0) begin n_errors++; $display("FAIL midrst_if_data: got %h want 0", if_data); end
    for (int i = 0; i < 6; i++) begin
      if (if_done) seen = 1'b1;
      @(posedge clk); #1;
    end
    $display("txn reset_mid_read: aborted fetch at 00000080");
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL midrst_no_done: got if_done pulse want none"); end
    run_txn("fetch_after_rst", 1'b1, 1'b0, 2'd2, 32'h100, 32'h0, lat, data);
    n_checks += 2;
    if (lat !== 6)             begin n_errors++; $display("FAIL midrst_latency: got %0d want 6", lat); end
    if (data !== 32'h00500513) begin n_errors++; $display("FAIL midrst_data: got %h want 00500513", data); end
  endtask

  task automatic test_wrap();
    int lat;
    logic [31:0] data;
    run_txn("wrap_half", 1'b0, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, lat, data);
    n_checks += 4;
    if (lat !== 4)             begin n_errors++; $display("FAIL wrap_latency: got %0d want 4", lat); end
    if (s_addr[1] !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL wrap_addr0: got %h want ffffffff", s_addr[1]); end
    if (s_addr[2] !== 32'h0)   begin n_errors++; $display("FAIL wrap_addr1: got %h want 00000000", s_addr[2]); end
    if (data !== 32'h00005AA5) begin n_errors++; $display("FAIL wrap_data: got %h want 00005aa5", data); end
  endtask

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_len = 2'd0; d_addr = '0; d_wdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_word_fetch();
    test_byte_load();
    test_word_store();
    test_simultaneous();
    test_reset_mid_read();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
